// File: rtl/ecg_pkg.sv
// Shared widths, FSM encodings and saturation limits for the ECG R-peak detector.
package ecg_pkg;

  localparam int IN_W  = 40;
  localparam int OUT_W = 24;
  localparam int RR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  localparam logic signed [OUT_W-1:0] Q_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Q_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic        [RR_W-1:0]  RR_MAX = {RR_W{1'b1}};

  // Saturating increment for the R-R counter and reported interval.
  function automatic logic [RR_W-1:0] rr_sat_inc(input logic [RR_W-1:0] c);
    logic [RR_W-1:0] r;
    if (c == RR_MAX) begin
      r = RR_MAX;
    end else begin
      r = c + {{(RR_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/ecg_requant.sv
// Combinational round-half-up, arithmetic shift and saturation of the filter
// output into the detector's narrower sample domain.
module ecg_requant
  import ecg_pkg::*;
#(
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  in_sample,
  output logic signed [OUT_W-1:0] q_out
);

  // One extra bit of headroom so the rounding add can never wrap.
  localparam logic signed [IN_W:0] RND = {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] HI  = {{(IN_W-OUT_W+1){1'b0}}, Q_MAX};
  localparam logic signed [IN_W:0] LO  = {{(IN_W-OUT_W+1){1'b1}}, Q_MIN};

  logic signed [IN_W:0] sum_s;
  logic signed [IN_W:0] shr_s;

  assign sum_s = {in_sample[IN_W-1], in_sample} + RND;
  assign shr_s = sum_s >>> SHIFT;

  // Clamp the shifted value into the signed OUT_W range.
  always_comb begin
    q_out = shr_s[OUT_W-1:0];
    if (shr_s > HI) begin
      q_out = Q_MAX;
    end else if (shr_s < LO) begin
      q_out = Q_MIN;
    end else begin
      q_out = shr_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ecg_peak_detector.sv
// R-peak detector: requantizes the filtered ECG stream and runs a
// threshold / search / refractory FSM reporting peak amplitude and R-R interval.
module ecg_peak_detector
  import ecg_pkg::*;
#(
  parameter int SHIFT      = 16,
  parameter int THRESH     = 1000,
  parameter int SEARCH_WIN = 36,
  parameter int REFRACT    = 72
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  In1,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    peak_valid,
  output logic signed [OUT_W-1:0] peak_amp,
  output logic        [RR_W-1:0]  rr_interval
);

  localparam int WC_W = $clog2(SEARCH_WIN + 1);
  localparam int RC_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic        [WC_W-1:0]  WIN_LIM  = WC_W'(SEARCH_WIN);
  localparam logic        [WC_W-1:0]  WC_ONE   = WC_W'(1);
  localparam logic        [RC_W-1:0]  REF_INIT = RC_W'(REFRACT);
  localparam logic        [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic signed [OUT_W-1:0] THR      = OUT_W'(THRESH);

  logic signed [OUT_W-1:0] q_s;
  logic                    eval_s;

  logic signed [OUT_W-1:0] sample_out_r;
  logic                    sample_valid_r;
  logic                    pend_r;   // registered sample not yet seen by the FSM
  state_t                  state_r;
  logic signed [OUT_W-1:0] max_r;
  logic        [WC_W-1:0]  win_r;
  logic        [RC_W-1:0]  ref_r;
  logic        [RR_W-1:0]  rr_cnt_r;
  logic                    first_r;
  logic                    peak_valid_r;
  logic signed [OUT_W-1:0] peak_amp_r;
  logic        [RR_W-1:0]  rr_interval_r;

  state_t                  state_nxt_s;
  logic signed [OUT_W-1:0] max_nxt_s;
  logic signed [OUT_W-1:0] cand_s;
  logic        [WC_W-1:0]  win_nxt_s;
  logic        [RC_W-1:0]  ref_nxt_s;
  logic        [RR_W-1:0]  rr_cnt_nxt_s;
  logic                    first_nxt_s;
  logic                    emit_s;
  logic signed [OUT_W-1:0] emit_amp_s;
  logic        [RR_W-1:0]  rr_out_s;

  ecg_requant #(.SHIFT(SHIFT)) u_requant (
    .in_sample (In1),
    .q_out     (q_s)
  );

  // A pending sample survives a clk_enable=0 stall and is evaluated on resume.
  assign eval_s = clk_enable & pend_r;

  // Requantized sample register; strobe is cleared whenever the enable drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out_r   <= {OUT_W{1'b0}};
      sample_valid_r <= 1'b0;
      pend_r         <= 1'b0;
    end else if (clk_enable) begin
      sample_valid_r <= in_valid;
      pend_r         <= in_valid;
      if (in_valid) begin
        sample_out_r <= q_s;
      end
    end else begin
      sample_valid_r <= 1'b0;
    end
  end

  // Detector FSM next-state, running max, counters and emission decision.
  always_comb begin
    state_nxt_s  = state_r;
    max_nxt_s    = max_r;
    cand_s       = max_r;
    win_nxt_s    = win_r;
    ref_nxt_s    = ref_r;
    rr_cnt_nxt_s = rr_cnt_r;
    first_nxt_s  = first_r;
    emit_s       = 1'b0;
    emit_amp_s   = max_r;
    rr_out_s     = first_r ? {RR_W{1'b0}} : rr_sat_inc(rr_cnt_r);
    if (eval_s) begin
      case (state_r)
        ST_IDLE: begin
          if (sample_out_r > THR) begin
            state_nxt_s = ST_SEARCH;
            max_nxt_s   = sample_out_r;
            win_nxt_s   = WC_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SEARCH: begin
          if (sample_out_r <= THR) begin
            emit_s     = 1'b1;
            emit_amp_s = max_r;
          end else begin
            // Strict compare keeps the earliest of equal maxima.
            if (sample_out_r > max_r) begin
              cand_s = sample_out_r;
            end else begin
              cand_s = max_r;
            end
            max_nxt_s = cand_s;
            win_nxt_s = win_r + WC_ONE;
            if (win_nxt_s == WIN_LIM) begin
              emit_s     = 1'b1;
              emit_amp_s = cand_s;
            end else begin
              emit_s = 1'b0;
            end
          end
        end
        ST_REFRACT: begin
          ref_nxt_s = ref_r - RC_ONE;
          if (ref_r == RC_ONE) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_REFRACT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
      if (emit_s) begin
        if (REFRACT == 0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REFRACT;
        end
        ref_nxt_s    = REF_INIT;
        rr_cnt_nxt_s = {RR_W{1'b0}};
        first_nxt_s  = 1'b0;
      end else if (!first_r) begin
        rr_cnt_nxt_s = rr_sat_inc(rr_cnt_r);
      end else begin
        rr_cnt_nxt_s = rr_cnt_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and counter registers; everything holds while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      max_r    <= {OUT_W{1'b0}};
      win_r    <= {WC_W{1'b0}};
      ref_r    <= {RC_W{1'b0}};
      rr_cnt_r <= {RR_W{1'b0}};
      first_r  <= 1'b1;
    end else if (clk_enable) begin
      state_r  <= state_nxt_s;
      max_r    <= max_nxt_s;
      win_r    <= win_nxt_s;
      ref_r    <= ref_nxt_s;
      rr_cnt_r <= rr_cnt_nxt_s;
      first_r  <= first_nxt_s;
    end
  end

  // Peak report registers; amplitude and interval hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid_r  <= 1'b0;
      peak_amp_r    <= {OUT_W{1'b0}};
      rr_interval_r <= {RR_W{1'b0}};
    end else if (clk_enable) begin
      peak_valid_r <= emit_s;
      if (emit_s) begin
        peak_amp_r    <= emit_amp_s;
        rr_interval_r <= rr_out_s;
      end
    end else begin
      peak_valid_r <= 1'b0;
    end
  end

  assign sample_out   = sample_out_r;
  assign sample_valid = sample_valid_r;
  assign peak_valid   = peak_valid_r;
  assign peak_amp     = peak_amp_r;
  assign rr_interval  = rr_interval_r;

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Self-checking bench for ecg_peak_detector: requant vector table, hand-written
// peak / refractory / gating / reset sequences, and randomized streams checked
// against an index-based reference model of the detection rules.
module tb_ecg_peak_detector;
  import ecg_pkg::*;

  localparam longint THRESH     = 1000;
  localparam int     SEARCH_WIN = 36;
  localparam int     REFRACT    = 72;

  typedef logic signed [IN_W-1:0] smp_t;
  typedef struct {int idx; longint amp; longint rr;} pk_t;
  typedef struct {smp_t in1; longint q;} rq_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b0;
  logic in_valid = 1'b0;
  smp_t In1 = '0;
  logic signed [OUT_W-1:0] sample_out;
  logic signed [OUT_W-1:0] peak_amp;
  logic sample_valid;
  logic peak_valid;
  logic [RR_W-1:0] rr_interval;

  int errors = 0;
  int checks = 0;
  int sv_cnt = 0;
  longint exp_sq[$];
  pk_t got[$];
  pk_t exp_pk[$];
  smp_t stim[$];
  pk_t mon_p;
  rq_t tbl[8];
  longint ua, ur;

  ecg_peak_detector dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .in_valid     (in_valid),
    .In1          (In1),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .peak_valid   (peak_valid),
    .peak_amp     (peak_amp),
    .rr_interval  (rr_interval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ref_q(input smp_t v);
    longint x;
    x = (longint'(v) + 32768) >>> 16;
    if (x > 8388607) x = 8388607;
    else if (x < -8388608) x = -8388608;
    return x;
  endfunction

  // Monitor: checks every requantized sample and records every peak pulse
  // together with the index of the sample that produced it.
  always @(negedge clk) begin
    if (!reset) begin
      sv_cnt = 0;
      got.delete();
      exp_sq.delete();
    end else begin
      if (peak_valid) begin
        mon_p.idx = sv_cnt - 1;
        mon_p.amp = longint'(peak_amp);
        mon_p.rr  = longint'(rr_interval);
        got.push_back(mon_p);
      end
      if (sample_valid) begin
        chk("sample_expected", longint'(exp_sq.size() > 0), 1);
        if (exp_sq.size() > 0) chk("sample_out", longint'(sample_out), exp_sq.pop_front());
        sv_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input smp_t v);
    In1 = v;
    in_valid = 1'b1;
    clk_enable = 1'b1;
    exp_sq.push_back(ref_q(v));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_enable = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic add(input longint q, input int n);
    repeat (n) stim.push_back(smp_t'(q) <<< 16);
  endtask

  // Reference: scan the accepted-sample sequence by index. A search opens on a
  // sample above threshold and closes on the first sample at/below threshold or
  // after SEARCH_WIN above-threshold samples; the next REFRACT samples are skipped.
  task automatic build_model(input smp_t s[$]);
    int i, e, cnt, last;
    longint mx, qj;
    pk_t p;
    exp_pk.delete();
    last = -1;
    i = 0;
    while (i < s.size()) begin
      if (ref_q(s[i]) > THRESH) begin
        mx = ref_q(s[i]);
        cnt = 1;
        e = -1;
        for (int j = i + 1; j < s.size(); j++) begin
          qj = ref_q(s[j]);
          if (qj <= THRESH) begin e = j; break; end
          if (qj > mx) mx = qj;
          cnt++;
          if (cnt == SEARCH_WIN) begin e = j; break; end
        end
        if (e < 0) break;
        p.idx = e;
        p.amp = mx;
        p.rr  = (last < 0) ? 0 : ((e - last > 65535) ? 65535 : e - last);
        exp_pk.push_back(p);
        last = e;
        i = e + 1 + REFRACT;
      end else begin
        i++;
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_npeaks"}, got.size(), exp_pk.size());
    for (int i = 0; i < exp_pk.size() && i < got.size(); i++) begin
      chk({tag, "_idx"}, got[i].idx, exp_pk[i].idx);
      chk({tag, "_amp"}, got[i].amp, exp_pk[i].amp);
      chk({tag, "_rr"},  got[i].rr,  exp_pk[i].rr);
    end
  endtask

  task automatic run(input smp_t s[$], input bit rst, input bit gaps, input string tag);
    if (rst) do_reset();
    build_model(s);
    foreach (s[i]) begin
      send(s[i]);
      if (gaps) idle($urandom_range(0, 2));
    end
    idle(4);
    compare(tag);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_sample_out", longint'(sample_out), 0);
    chk("rst_sample_valid", longint'(sample_valid), 0);
    chk("rst_peak_valid", longint'(peak_valid), 0);
    chk("rst_peak_amp", longint'(peak_amp), 0);
    chk("rst_rr", longint'(rr_interval), 0);
    reset = 1'b1;
    tick();

    // Requantization vectors
    tbl[0] = '{smp_t'(98304), 2};
    tbl[1] = '{-smp_t'(98304), -1};
    tbl[2] = '{smp_t'(32767), 0};
    tbl[3] = '{smp_t'(32768), 1};
    tbl[4] = '{-smp_t'(32768), 0};
    tbl[5] = '{-smp_t'(32769), -1};
    tbl[6] = '{{1'b0, {(IN_W-1){1'b1}}}, 8388607};
    tbl[7] = '{{1'b1, {(IN_W-1){1'b0}}}, -8388608};
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].in1);
      chk("rq_valid", longint'(sample_valid), 1);
      chk("rq_value", longint'(sample_out), tbl[i].q);
      idle(1);
      chk("rq_strobe_end", longint'(sample_valid), 0);
    end

    // Basic peak with exact 2-cycle latency
    do_reset();
    send(smp_t'(0));
    send(smp_t'(500) <<< 16);
    send(smp_t'(1200) <<< 16);
    send(smp_t'(3000) <<< 16);
    send(smp_t'(2500) <<< 16);
    send(smp_t'(900) <<< 16);
    chk("basic_early", longint'(peak_valid), 0);
    tick();
    chk("basic_pulse", longint'(peak_valid), 1);
    chk("basic_amp", longint'(peak_amp), 3000);
    chk("basic_rr", longint'(rr_interval), 0);
    tick();
    chk("basic_pulse_end", longint'(peak_valid), 0);
    chk("basic_amp_hold", longint'(peak_amp), 3000);
    chk("basic_count", got.size(), 1);

    // Window expiry
    stim.delete();
    add(2000, 10); add(4000, 1); add(2000, 29);
    run(stim, 1'b1, 1'b0, "window");
    if (got.size() > 0) begin
      chk("window_idx", got[0].idx, 35);
      chk("window_amp", got[0].amp, 4000);
    end

    // R-R interval and refractory masking
    stim.delete();
    add(0, 1); add(3000, 1); add(0, 8); add(5000, 1); add(0, 89);
    add(2500, 1); add(2600, 1); add(0, 1);
    run(stim, 1'b1, 1'b0, "rr");
    chk("rr_count", got.size(), 2);
    if (got.size() > 1) begin
      chk("rr_value", got[1].rr, 100);
      chk("rr_amp", got[1].amp, 2600);
    end

    // Enable gating: ungated reference run, then the same stream stalled mid-search
    stim.delete();
    add(0, 1); add(3000, 1); add(0, 98);
    add(2000, 2); add(4500, 1); add(2000, 2); add(0, 1);
    run(stim, 1'b1, 1'b0, "ungated");
    ua = (got.size() > 0) ? got[got.size()-1].amp : -1;
    ur = (got.size() > 0) ? got[got.size()-1].rr  : -1;
    do_reset();
    build_model(stim);
    foreach (stim[i]) begin
      if (i == 102) begin
        clk_enable = 1'b0;
        in_valid = 1'b1;
        In1 = smp_t'(7000) <<< 16;
        repeat (5) begin
          tick();
          chk("gate_sample_valid", longint'(sample_valid), 0);
          chk("gate_peak_valid", longint'(peak_valid), 0);
        end
        in_valid = 1'b0;
        clk_enable = 1'b1;
      end
      send(stim[i]);
    end
    idle(4);
    compare("gated");
    if (got.size() > 0) begin
      chk("gated_amp_vs_ungated", got[got.size()-1].amp, ua);
      chk("gated_rr_vs_ungated", got[got.size()-1].rr, ur);
    end

    // Asynchronous reset mid-search, then first peak reports rr=0
    stim.delete();
    add(0, 1); add(3000, 1); add(0, 101); add(2000, 1); add(3000, 1);
    run(stim, 1'b1, 1'b0, "pre_reset");
    reset = 1'b0;
    #1;
    chk("async_sample_out", longint'(sample_out), 0);
    chk("async_sample_valid", longint'(sample_valid), 0);
    chk("async_peak_valid", longint'(peak_valid), 0);
    chk("async_peak_amp", longint'(peak_amp), 0);
    chk("async_rr", longint'(rr_interval), 0);
    tick();
    reset = 1'b1;
    tick();
    stim.delete();
    add(0, 1); add(500, 1); add(1200, 1); add(3000, 1); add(2500, 1); add(900, 1);
    run(stim, 1'b0, 1'b0, "post_reset");
    if (got.size() > 0) chk("post_reset_rr", got[0].rr, 0);

    // Randomized streams against the reference model
    for (int seg = 0; seg < 3; seg++) begin
      stim.delete();
      while (stim.size() < 400) begin
        int r;
        longint q;
        r = $urandom_range(0, 9);
        if (r < 5) begin
          q = longint'($urandom_range(0, 2000)) - 1000;
          stim.push_back((smp_t'(q) <<< 16) + smp_t'($urandom_range(0, 65535)) - smp_t'(32768));
        end else if (r < 9) begin
          repeat ($urandom_range(1, 45)) begin
            q = longint'($urandom_range(990, 9000));
            stim.push_back((smp_t'(q) <<< 16) + smp_t'($urandom_range(0, 65535)) - smp_t'(32768));
          end
        end else begin
          stim.push_back(smp_t'({$urandom(), $urandom()}));
        end
      end
      run(stim, 1'b1, 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
